// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with ALU-control decode.
// Captures the ALU operands, the 4-bit ALU control and the destination
// register with a valid/ready handshake on both sides.
// Optional build macro ID_EX_SKID_EN adds a skid register so that in_ready
// depends only on registered state. Without it, a single output register is
// used and in_ready looks through to out_ready.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_opcode,
  input  logic [1:0]  in_alu_op,
  input  logic [63:0] in_rs1_data,
  input  logic [63:0] in_rs2_data,
  input  logic [63:0] in_imm,
  input  logic        in_alu_src,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_input_1,
  output logic [63:0] out_input_2,
  output logic [3:0]  out_alu_ctrl,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t in_entry;
  entry_t out_q;
  logic   out_vld;
  logic   in_fire;

  // Decode ALUOp/opcode into the ALU control code; anything unknown is 1111.
  always_comb begin
    in_entry.op1     = in_rs1_data;
    in_entry.op2     = in_alu_src ? in_imm : in_rs2_data;
    in_entry.rd      = in_rd;
    in_entry.ctrl    = 4'b1111;
    in_entry.illegal = 1'b1;
    case (in_alu_op)
      2'b00: begin in_entry.ctrl = 4'b0010; in_entry.illegal = 1'b0; end
      2'b01: begin in_entry.ctrl = 4'b0110; in_entry.illegal = 1'b0; end
      2'b10: begin
        in_entry.illegal = 1'b0;
        case (in_opcode)
          11'b10001011000: in_entry.ctrl = 4'b0010; // ADD
          11'b11001011000: in_entry.ctrl = 4'b0110; // SUB
          11'b10001010000: in_entry.ctrl = 4'b0000; // AND
          11'b10101010000: in_entry.ctrl = 4'b0001; // ORR
          11'b10011011000: in_entry.ctrl = 4'b0111; // MUL
          11'b10011010110: in_entry.ctrl = 4'b0011; // SDIV
          default: begin
            in_entry.ctrl    = 4'b1111;
            in_entry.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        in_entry.ctrl    = 4'b1111;
        in_entry.illegal = 1'b1;
      end
    endcase
  end

  assign in_fire      = in_valid & in_ready;
  assign out_valid    = out_vld;
  assign out_input_1  = out_q.op1;
  assign out_input_2  = out_q.op2;
  assign out_alu_ctrl = out_q.ctrl;
  assign out_rd       = out_q.rd;
  assign out_illegal  = out_q.illegal;

`ifdef ID_EX_SKID_EN
  entry_t skid_q;
  logic   skid_vld;

  // Registered ready: only a full skid register back-pressures upstream.
  assign in_ready = ~skid_vld;

  // EMPTY/ONE/FULL tracked by (out_vld, skid_vld); skid drains into output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // FULL: upstream is blocked, promote skid once output drains
      if (out_ready) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (out_vld && !out_ready) begin
      // ONE and stalled: a new entry parks in the skid register
      if (in_fire) begin
        skid_q   <= in_entry;
        skid_vld <= 1'b1;
      end
    end else begin
      // EMPTY or draining: new entry goes straight to the output
      if (in_fire) begin
        out_q   <= in_entry;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end
`else
  // Single register: accept when empty or when the held entry leaves now.
  assign in_ready = ~out_vld | out_ready;

  // Load on input transfer, clear valid when the held entry drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (in_fire) begin
      out_q   <= in_entry;
      out_vld <= 1'b1;
    end else if (out_ready) begin
      out_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed stimulus with a scoreboard queue. The driver
// pushes the hand-computed expected entry whenever an input transfer is
// about to happen; a separate monitor pops and compares every output transfer.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_opcode;
  logic [1:0]  in_alu_op;
  logic [63:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_input_1, out_input_2;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_illegal;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDO = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] MUL  = 11'b10011011000;
  localparam logic [10:0] SDIV = 11'b10011010110;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_alu_op(in_alu_op),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_rd(in_rd),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_input_1(out_input_1), .out_input_2(out_input_2),
    .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got op1=%0h op2=%0h ctrl=%0h rd=%0d, want nothing",
                 out_input_1, out_input_2, out_alu_ctrl, out_rd);
      end else begin
        e = q.pop_front();
        if ({out_input_1, out_input_2, out_alu_ctrl, out_rd, out_illegal} !==
            {e.a, e.b, e.c, e.rd, e.ill}) begin
          n_err++;
          $display("FAIL entry: got op1=%0h op2=%0h ctrl=%b rd=%0d ill=%b, want op1=%0h op2=%0h ctrl=%b rd=%0d ill=%b",
                   out_input_1, out_input_2, out_alu_ctrl, out_rd, out_illegal,
                   e.a, e.b, e.c, e.rd, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [10:0] op, input logic [1:0] aop, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im, input logic s, input logic [4:0] d);
    in_opcode = op; in_alu_op = aop; in_rs1_data = a; in_rs2_data = b;
    in_imm = im; in_alu_src = s; in_rd = d;
  endtask

  // Present one instruction until accepted (bounded), queueing its expectation.
  task automatic send(input logic [10:0] op, input logic [1:0] aop, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] im, input logic s,
                      input logic [4:0] d, input logic [3:0] c);
    exp_t e;
    bit acc;
    acc = 1'b0;
    set_in(op, aop, a, b, im, s, d);
    in_valid = 1'b1;
    e.a = a; e.b = s ? im : b; e.c = c; e.rd = d; e.ill = (c == 4'b1111);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        acc = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no in_ready in 20 cycles, want acceptance");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    // An instruction offered during reset must be ignored.
    in_valid = 1'b1;
    set_in(ADD, 2'b10, 64'h55, 64'h66, 64'h0, 1'b0, 5'd9);
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op1", out_input_1, 0);
    chk("rst_op2", out_input_2, 0);
    chk("rst_ctrl", out_alu_ctrl, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Basic ADD with latency one.
    out_ready = 1'b1;
    send(ADD, 2'b10, 64'd5, 64'd7, 64'd0, 1'b0, 5'd3, 4'b0010);
    @(negedge clk);
    chk("lat1_valid", out_valid, 1);
    chk("lat1_op2", out_input_2, 7);
    chk("lat1_ctrl", out_alu_ctrl, 4'b0010);
    tick();

    // Back-to-back stream covering every decode row.
    send(11'h7C2, 2'b00, 64'd100, 64'd999, 64'h10, 1'b1, 5'd4, 4'b0010);
    send(11'h5A0, 2'b01, 64'd9, 64'd8, 64'd0, 1'b0, 5'd0, 4'b0110);
    send(SDIV, 2'b10, 64'd40, 64'd5, 64'd0, 1'b0, 5'd10, 4'b0011);
    send(11'd0, 2'b10, 64'd1, 64'd2, 64'd0, 1'b0, 5'd11, 4'b1111);
    send(SUB, 2'b10, 64'hFFFF_0000_0000_0001, 64'd3, 64'd0, 1'b0, 5'd12, 4'b0110);
    send(ANDO, 2'b10, 64'hF0, 64'h3C, 64'd0, 1'b0, 5'd13, 4'b0000);
    send(ORR, 2'b10, 64'h0F, 64'hA0, 64'h77, 1'b1, 5'd14, 4'b0001);
    send(MUL, 2'b10, 64'd6, 64'd7, 64'd0, 1'b0, 5'd15, 4'b0111);
    send(ADD, 2'b11, 64'd3, 64'd4, 64'd0, 1'b0, 5'd31, 4'b1111);
    repeat (3) tick();
    chk("stream_drained", q.size(), 0);

    // Stall: A held stable while B waits (skid build) or is refused (plain build).
    out_ready = 1'b0;
    send(ADD, 2'b10, 64'h111, 64'h222, 64'd0, 1'b0, 5'd7, 4'b0010);
    fork
      send(SUB, 2'b10, 64'h333, 64'h444, 64'd0, 1'b0, 5'd8, 4'b0110);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_op1", out_input_1, 64'h111);
          chk("stall_rd", out_rd, 7);
          if (k > 0) chk("stall_in_ready", in_ready, 0);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();
    @(negedge clk);
    chk("stall_in_ready_back", in_ready, 1);
    chk("stall_drained", q.size(), 0);
    tick();

    // Flush while holding entries, with a same-cycle offered instruction.
    out_ready = 1'b0;
    send(ORR, 2'b10, 64'hAA, 64'hBB, 64'd0, 1'b0, 5'd20, 4'b0001);
`ifdef ID_EX_SKID_EN
    send(MUL, 2'b10, 64'hCC, 64'hDD, 64'd0, 1'b0, 5'd21, 4'b0111);
`endif
    set_in(SUB, 2'b10, 64'hEE, 64'hFF, 64'd0, 1'b0, 5'd22);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_stays_empty", out_valid, 0);
      tick();
    end

    // Reset while stalled (FULL in the skid build) with an instruction offered.
    out_ready = 1'b0;
    send(MUL, 2'b10, 64'h1234, 64'h5678, 64'd0, 1'b0, 5'd25, 4'b0111);
`ifdef ID_EX_SKID_EN
    send(ANDO, 2'b10, 64'h9, 64'hA, 64'd0, 1'b0, 5'd26, 4'b0000);
`endif
    set_in(ADD, 2'b10, 64'h42, 64'h43, 64'd0, 1'b0, 5'd27);
    in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_op1", out_input_1, 0);
    chk("rst2_op2", out_input_2, 0);
    chk("rst2_ctrl", out_alu_ctrl, 0);
    chk("rst2_rd", out_rd, 0);
    chk("rst2_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst2_stays_empty", out_valid, 0);
    tick();

    // Recovery after reset.
    send(SUB, 2'b10, 64'd50, 64'd8, 64'd0, 1'b0, 5'd1, 4'b0110);
    repeat (3) tick();
    chk("final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
